// File: rtl/lsu_rmw.sv
// Multicycle load/store unit: one access at a time toward a word-wide memory with a
// variable-latency ack. Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module lsu_rmw #(
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready; the unit
  // answers with a single-cycle rsp_valid pulse that cannot be stalled.

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  state_t            state_q, state_d;
  logic              wen_q, wen_d;
  logic [1:0]        lo_q, lo_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic misaligned;
  logic timed_out;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [15:0] wd,
                                             input logic [1:0] lo, input logic [1:0] size);
    logic [31:0] w;
    w = old_w;
    if (size == SZ_HALF) begin
      if (lo[1]) w[31:16] = wd;
      else       w[15:0]  = wd;
    end else begin
      case (lo)
        2'd0:    w[7:0]   = wd[7:0];
        2'd1:    w[15:8]  = wd[7:0];
        2'd2:    w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end
    return w;
  endfunction

  function automatic logic [31:0] extract_word(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  // Last allowed wait cycle passed without an ack; TIMEOUT of 0 never fires.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !mem_ack;

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    lo_d        = lo_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = ERR_OK;
    mem_en_d    = mem_en_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d       = req_wen;
          lo_d        = req_addr[1:0];
          size_d      = req_size;
          uns_d       = req_unsigned;
          wdata_d     = req_wdata[15:0];
          cnt_d       = '0;
          req_ready_d = 1'b0;
          if (misaligned) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ALIGN;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_wen && (req_size == SZ_WORD)) begin
              state_d     = S_WR;
              mem_wen_d   = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d     = S_RD;
              mem_wen_d   = 1'b0;
              mem_wdata_d = '0;
            end
          end
        end
      end

      S_RD: begin
        if (mem_ack) begin
          if (wen_q) begin
            // The read word is the merge buffer: only the addressed lane changes.
            state_d     = S_WR;
            mem_wen_d   = 1'b1;
            mem_wdata_d = merge_word(mem_rdata, wdata_q, lo_q, size_q);
            cnt_d       = '0;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = extract_word(mem_rdata, lo_q, size_q, uns_q);
            mem_en_d    = 1'b0;
            mem_addr_d  = '0;
          end
        end else if (timed_out) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TMO;
          mem_en_d    = 1'b0;
          mem_addr_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WR: begin
        if (mem_ack || timed_out) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = mem_ack ? ERR_OK : ERR_TMO;
          mem_en_d    = 1'b0;
          mem_wen_d   = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        mem_en_d    = 1'b0;
        mem_wen_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wen_q       <= 1'b0;
      lo_q        <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = !req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
